// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: run-time writable 8-bit instruction memory plus jump-label
// table, decoded through a registered valid/ready output stage.
// A fetch accepted on one edge is presented on dec_* after that edge.
// Optional build macro INSTR_FETCH_SKID_EN: replaces the single output register
// with a 2-entry FIFO whose fetch_ready depends only on registered occupancy.
module instr_fetch_decode #(
  parameter int ADDR_W  = 8,
  parameter int PC_W    = 16,
  parameter int LABEL_N = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              lbl_we,
  input  logic [3:0]        lbl_idx,
  input  logic [PC_W-1:0]   lbl_data,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              flush,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [PC_W-1:0]   dec_pc,
  output logic [1:0]        format,
  output logic [3:0]        opcode,
  output logic [2:0]        reg1_i,
  output logic [2:0]        reg2_i,
  output logic [2:0]        reg_o,
  output logic [2:0]        imm,
  output logic              imm_flag,
  output logic [PC_W-1:0]   jmp_loc,
  output logic              oob
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] FMT_C = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_M = 2'b10;
  localparam logic [1:0] FMT_X = 2'b11;

  // HALT is substituted for any PC that lies beyond program memory.
  localparam logic [7:0] HALT_INSTR = 8'hE0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [1:0]      fmt;
    logic [3:0]      opcode;
    logic [2:0]      reg1;
    logic [2:0]      reg2;
    logic [2:0]      rego;
    logic [2:0]      imm;
    logic            imm_flag;
    logic [PC_W-1:0] jmp;
    logic            oob;
  } entry_t;

  logic [7:0]      mem   [DEPTH];
  logic [PC_W-1:0] label [LABEL_N];

  logic            accept;
  logic            oob_p0;
  logic [7:0]      instr_p0;
  logic [3:0]      lbl_sel_p0;
  logic            lbl_use_p0;
  logic [PC_W-1:0] lbl_rd_p0;
  entry_t          dec_p0;
  entry_t          head_p1;

  assign accept = fetch_valid && fetch_ready;

  // Program memory: written at run time, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Jump-label table: cleared by reset, rewritable at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LABEL_N; i++) begin
        label[i] <= '0;
      end
    end else if (lbl_we) begin
      label[lbl_idx] <= lbl_data;
    end
  end

  // ---- stage p0: fetch byte (write-first) and decode combinationally ----
  always_comb begin
    oob_p0   = |fetch_pc[PC_W-1:ADDR_W];
    instr_p0 = (prog_we && (prog_addr == fetch_pc[ADDR_W-1:0])) ? prog_data
                                                                : mem[fetch_pc[ADDR_W-1:0]];
    if (oob_p0) begin
      instr_p0 = HALT_INSTR;
    end

    dec_p0          = '0;
    lbl_sel_p0      = 4'd0;
    lbl_use_p0      = 1'b0;
    dec_p0.pc       = fetch_pc;
    dec_p0.opcode   = instr_p0[7:4];
    dec_p0.imm      = instr_p0[3:1];
    dec_p0.imm_flag = instr_p0[0];
    dec_p0.oob      = oob_p0;

    case (instr_p0[7:4])
      4'b0010, 4'b0100: begin
        dec_p0.fmt  = FMT_C;
        dec_p0.rego = instr_p0[0] ? 3'b011 : 3'b010;
        lbl_sel_p0  = instr_p0[3:0];
        lbl_use_p0  = 1'b1;
      end
      4'b1001, 4'b1101: begin
        dec_p0.fmt  = FMT_I;
        dec_p0.reg1 = instr_p0[3:1];
        dec_p0.reg2 = instr_p0[3:1] + 3'd1;
        dec_p0.rego = instr_p0[3:1];
      end
      4'b1110, 4'b1111: begin
        dec_p0.fmt = FMT_X;
      end
      4'b0101: begin
        dec_p0.fmt  = FMT_M;
        dec_p0.reg1 = {1'b1, instr_p0[1:0]};
        dec_p0.rego = {1'b0, instr_p0[3:2]};
        lbl_sel_p0  = {2'b11, instr_p0[1:0]};
        lbl_use_p0  = 1'b1;
      end
      default: begin
        dec_p0.fmt  = FMT_M;
        dec_p0.reg1 = {1'b0, instr_p0[3:2]};
        dec_p0.reg2 = {1'b0, instr_p0[3:2]} + 3'd1;
        dec_p0.rego = {1'b1, instr_p0[1:0]};
        lbl_sel_p0  = {2'b11, instr_p0[1:0]};
        lbl_use_p0  = 1'b1;
      end
    endcase

    lbl_rd_p0  = (lbl_we && (lbl_idx == lbl_sel_p0)) ? lbl_data : label[lbl_sel_p0];
    dec_p0.jmp = lbl_use_p0 ? lbl_rd_p0 : '0;
  end

`ifdef INSTR_FETCH_SKID_EN
  entry_t     fifo_p1 [2];
  logic       rd_ptr_p1;
  logic       wr_ptr_p1;
  logic [1:0] cnt_p1;
  logic       pop;

  assign fetch_ready = (cnt_p1 != 2'd2);
  assign dec_valid   = (cnt_p1 != 2'd0);
  assign pop         = dec_valid && dec_ready;
  assign head_p1     = fifo_p1[rd_ptr_p1];

  // ---- stage p1: 2-entry output FIFO, flush empties it ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p1     <= 2'd0;
      rd_ptr_p1  <= 1'b0;
      wr_ptr_p1  <= 1'b0;
      fifo_p1[0] <= '0;
      fifo_p1[1] <= '0;
    end else if (flush) begin
      cnt_p1    <= 2'd0;
      rd_ptr_p1 <= 1'b0;
      wr_ptr_p1 <= 1'b0;
    end else begin
      if (accept) begin
        fifo_p1[wr_ptr_p1] <= dec_p0;
        wr_ptr_p1          <= !wr_ptr_p1;
      end
      if (pop) begin
        rd_ptr_p1 <= !rd_ptr_p1;
      end
      cnt_p1 <= cnt_p1 + {1'b0, accept} - {1'b0, pop};
    end
  end
`else
  entry_t entry_p1;
  logic   vld_p1;

  assign fetch_ready = !vld_p1 || dec_ready;
  assign dec_valid   = vld_p1;
  assign head_p1     = entry_p1;

  // ---- stage p1: single output register, held while the consumer stalls ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      entry_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      entry_p1 <= dec_p0;
    end else if (dec_ready) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

  assign dec_pc   = head_p1.pc;
  assign format   = head_p1.fmt;
  assign opcode   = head_p1.opcode;
  assign reg1_i   = head_p1.reg1;
  assign reg2_i   = head_p1.reg2;
  assign reg_o    = head_p1.rego;
  assign imm      = head_p1.imm;
  assign imm_flag = head_p1.imm_flag;
  assign jmp_loc  = head_p1.jmp;
  assign oob      = head_p1.oob;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode (default and INSTR_FETCH_SKID_EN builds).
module tb_instr_fetch_decode;

  localparam int ADDR_W = 8;
  localparam int PC_W   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;
  logic              lbl_we;
  logic [3:0]        lbl_idx;
  logic [PC_W-1:0]   lbl_data;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [PC_W-1:0]   fetch_pc;
  logic              flush;
  logic              dec_valid;
  logic              dec_ready;
  logic [PC_W-1:0]   dec_pc;
  logic [1:0]        format;
  logic [3:0]        opcode;
  logic [2:0]        reg1_i;
  logic [2:0]        reg2_i;
  logic [2:0]        reg_o;
  logic [2:0]        imm;
  logic              imm_flag;
  logic [PC_W-1:0]   jmp_loc;
  logic              oob;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [256];
  logic [15:0] lbl_m [16];
  logic [51:0] sb_q [$];

  always #5 clk = ~clk;

  instr_fetch_decode #(.ADDR_W(ADDR_W), .PC_W(PC_W), .LABEL_N(16)) dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .lbl_we(lbl_we), .lbl_idx(lbl_idx), .lbl_data(lbl_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .format(format), .opcode(opcode), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .reg_o(reg_o), .imm(imm), .imm_flag(imm_flag), .jmp_loc(jmp_loc), .oob(oob)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [51:0] obs_pack();
    return {dec_pc, format, opcode, reg1_i, reg2_i, reg_o, imm, imm_flag, jmp_loc, oob};
  endfunction

  // Reference decode of a fetch as seen just before the accepting edge.
  function automatic logic [51:0] exp_decode(input logic [15:0] pc);
    logic [7:0]  b;
    logic        o;
    logic [1:0]  f;
    logic [2:0]  r1, r2, ro;
    logic [3:0]  li;
    logic        use_l;
    logic [15:0] j;
    o = (pc > 16'h00FF);
    if (o) b = 8'hE0;
    else if (prog_we && prog_addr == pc[7:0]) b = prog_data;
    else b = mem_m[pc[7:0]];
    r1 = 3'd0; r2 = 3'd0; ro = 3'd0; li = 4'd0; use_l = 1'b0; f = 2'b10;
    case (b[7:4])
      4'h2, 4'h4: begin f = 2'b00; ro = b[0] ? 3'd3 : 3'd2; li = b[3:0]; use_l = 1'b1; end
      4'h9, 4'hD: begin f = 2'b01; r1 = b[3:1]; r2 = (b[3:1] == 3'd7) ? 3'd0 : b[3:1] + 3'd1; ro = b[3:1]; end
      4'hE, 4'hF: f = 2'b11;
      4'h5: begin r1 = {1'b1, b[1:0]}; ro = {1'b0, b[3:2]}; li = {2'b11, b[1:0]}; use_l = 1'b1; end
      default: begin
        r1 = {1'b0, b[3:2]}; r2 = {1'b0, b[3:2]} + 3'd1; ro = {1'b1, b[1:0]};
        li = {2'b11, b[1:0]}; use_l = 1'b1;
      end
    endcase
    if (!use_l) j = 16'h0;
    else if (lbl_we && lbl_idx == li) j = lbl_data;
    else j = lbl_m[li];
    return {pc, f, b[7:4], r1, r2, ro, b[3:1], b[0], j, o};
  endfunction

  // Scoreboard monitor: inputs are stable at the falling edge, so this sees
  // exactly what the next rising edge will act upon.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      for (int i = 0; i < 16; i++) lbl_m[i] = 16'h0;
    end else begin
      if (dec_valid) begin
        if (sb_q.size() == 0) chk_eq("sb_extra", 64'(1), 64'(0));
        else begin
          chk_eq("sb_out", 64'(obs_pack()), 64'(sb_q[0]));
          if (dec_ready) void'(sb_q.pop_front());
        end
      end
      if (flush) sb_q.delete();
      else if (fetch_valid && fetch_ready) sb_q.push_back(exp_decode(fetch_pc));
      if (prog_we) mem_m[prog_addr] = prog_data;
      if (lbl_we) lbl_m[lbl_idx] = lbl_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_mem(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic wr_lbl(input logic [3:0] i, input logic [15:0] d);
    lbl_we = 1'b1; lbl_idx = i; lbl_data = d;
    tick();
    lbl_we = 1'b0;
  endtask

  task automatic fetch_one(input logic [15:0] pc);
    fetch_valid = 1'b1; fetch_pc = pc;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic drain();
    dec_ready = 1'b1;
    repeat (3) tick();
  endtask

  logic [15:0] pc_s;
  logic        acc;
  logic        rdy [3];
  int          guard;

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h0;
    for (int i = 0; i < 16; i++) lbl_m[i] = 16'h0;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    lbl_we = 1'b0; lbl_idx = '0; lbl_data = '0;
    fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0; dec_ready = 1'b0;
    #12;
    chk_eq("rst_valid", 64'(dec_valid), 64'(0));
    chk_eq("rst_outs", 64'(obs_pack()), 64'(0));
    chk_eq("rst_ready", 64'(fetch_ready), 64'(1));
    tick();
    reset = 1'b0;
    tick();

    // Program and label setup.
    wr_mem(8'd0, 8'h42); wr_mem(8'd1, 8'h76); wr_mem(8'd2, 8'h5A); wr_mem(8'd3, 8'hD1);
    wr_mem(8'd5, 8'h01); wr_mem(8'd6, 8'h9F); wr_mem(8'd7, 8'h2B); wr_mem(8'd8, 8'hF3);
    wr_mem(8'd9, 8'h13);
    wr_lbl(4'd2, 16'h000A); wr_lbl(4'd14, 16'h0030); wr_lbl(4'd11, 16'h1234);
    wr_lbl(4'd15, 16'h0F0F);

    // C-form fetch with single-cycle latency.
    fetch_one(16'h0000);
    chk_eq("c_valid", 64'(dec_valid), 64'(1));
    chk_eq("c_format", 64'(format), 64'(0));
    chk_eq("c_opcode", 64'(opcode), 64'(4));
    chk_eq("c_rego", 64'(reg_o), 64'(2));
    chk_eq("c_jmp", 64'(jmp_loc), 64'h000A);
    chk_eq("c_oob", 64'(oob), 64'(0));
    drain();

    // Back-to-back fetches, one result per cycle.
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch_valid = 1'b1; fetch_pc = 16'(k + 1);
      tick();
      chk_eq("b2b_valid", 64'(dec_valid), 64'(1));
      chk_eq("b2b_pc", 64'(dec_pc), 64'(k + 1));
      case (k)
        0: begin
          chk_eq("m76_regs", 64'({reg1_i, reg2_i, reg_o}), 64'({3'd1, 3'd2, 3'd6}));
          chk_eq("m76_jmp", 64'(jmp_loc), 64'h0030);
        end
        1: chk_eq("mvb_regs", 64'({reg1_i, reg2_i, reg_o}), 64'({3'd6, 3'd0, 3'd2}));
        default: begin
          chk_eq("i_format", 64'(format), 64'(1));
          chk_eq("i_fields", 64'({reg1_i, reg2_i, imm, imm_flag}), 64'({3'd0, 3'd1, 3'd0, 1'b1}));
          chk_eq("i_jmp", 64'(jmp_loc), 64'(0));
        end
      endcase
    end
    fetch_valid = 1'b0;
    tick();
    chk_eq("b2b_idle", 64'(dec_valid), 64'(0));

    // Consumer stall with a persistent requester.
    dec_ready = 1'b0; fetch_valid = 1'b1; pc_s = 16'd1;
    for (int c = 0; c < 3; c++) begin
      fetch_pc = pc_s;
      acc = fetch_ready;
      tick();
      if (acc) pc_s = pc_s + 16'd1;
      rdy[c] = fetch_ready;
      chk_eq("stall_head", 64'(dec_pc), 64'(1));
    end
`ifdef INSTR_FETCH_SKID_EN
    chk_eq("stall_rdy0", 64'(rdy[0]), 64'(1));
    chk_eq("stall_rdy1", 64'(rdy[1]), 64'(0));
    chk_eq("stall_acc", 64'(pc_s), 64'(3));
`else
    chk_eq("stall_rdy0", 64'(rdy[0]), 64'(0));
    chk_eq("stall_rdy1", 64'(rdy[1]), 64'(0));
    chk_eq("stall_acc", 64'(pc_s), 64'(2));
`endif
    chk_eq("stall_rdy2", 64'(rdy[2]), 64'(0));
    fetch_valid = 1'b0;
    drain();
    chk_eq("stall_done", 64'(dec_valid), 64'(0));

    // Out-of-range PC turns into HALT.
    dec_ready = 1'b0;
    fetch_one(16'h0100);
    chk_eq("oob_op", 64'({format, opcode}), 64'({2'b11, 4'b1110}));
    chk_eq("oob_flag", 64'(oob), 64'(1));
    chk_eq("oob_regs", 64'({reg1_i, reg2_i, reg_o}), 64'(0));
    drain();

    // Write-first on program memory and label table.
    dec_ready = 1'b0;
    prog_we = 1'b1; prog_addr = 8'd5; prog_data = 8'hE0;
    fetch_one(16'h0005);
    prog_we = 1'b0;
    chk_eq("wf_mem", 64'(opcode), 64'(14));
    drain();
    dec_ready = 1'b0;
    lbl_we = 1'b1; lbl_idx = 4'd2; lbl_data = 16'h0055;
    fetch_one(16'h0000);
    lbl_we = 1'b0;
    chk_eq("wf_lbl", 64'(jmp_loc), 64'h0055);
    wr_lbl(4'd2, 16'h7777);
    chk_eq("lbl_held", 64'(jmp_loc), 64'h0055);
    drain();

    // Register wrap, C-form with odd reg_o, X-form, plain M-form.
    dec_ready = 1'b1;
    fetch_one(16'h0006);
    chk_eq("wrap_regs", 64'({reg1_i, reg2_i, reg_o}), 64'({3'd7, 3'd0, 3'd7}));
    fetch_one(16'h0007);
    chk_eq("c2b", 64'({reg_o, jmp_loc}), 64'({3'd3, 16'h1234}));
    fetch_one(16'h0008);
    fetch_one(16'h0009);
    drain();

    // Flush with an entry buffered and a concurrent fetch.
    dec_ready = 1'b0;
    fetch_one(16'h0000);
    fetch_valid = 1'b1; fetch_pc = 16'h0001; flush = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    chk_eq("flush_valid", 64'(dec_valid), 64'(0));
    tick();
    chk_eq("flush_stays", 64'(dec_valid), 64'(0));

    // Asynchronous reset mid-stream; memory survives, labels do not.
    fetch_one(16'h0003);
    chk_eq("pre_rst", 64'(dec_valid), 64'(1));
    reset = 1'b1;
    #1;
    chk_eq("arst_valid", 64'(dec_valid), 64'(0));
    chk_eq("arst_outs", 64'(obs_pack()), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    fetch_one(16'h0000);
    chk_eq("mem_kept", 64'(opcode), 64'(4));
    chk_eq("lbl_reset", 64'(jmp_loc), 64'(0));
    drain();

    // Randomised traffic checked entirely by the scoreboard.
    for (int a = 16; a < 48; a++) wr_mem(8'(a), 8'($urandom));
    for (int i = 0; i < 16; i++) wr_lbl(4'(i), 16'($urandom));
    for (int c = 0; c < 400; c++) begin
      fetch_valid = ($urandom_range(3) != 0);
      fetch_pc    = ($urandom_range(7) == 0) ? 16'h0100 + 16'($urandom_range(255))
                                             : 16'(16 + $urandom_range(31));
      dec_ready   = ($urandom_range(2) != 0);
      flush       = ($urandom_range(29) == 0);
      prog_we     = ($urandom_range(9) == 0);
      prog_addr   = 8'(16 + $urandom_range(31));
      prog_data   = 8'($urandom);
      lbl_we      = ($urandom_range(7) == 0);
      lbl_idx     = 4'($urandom);
      lbl_data    = 16'($urandom);
      tick();
    end
    fetch_valid = 1'b0; flush = 1'b0; prog_we = 1'b0; lbl_we = 1'b0; dec_ready = 1'b1;
    guard = 0;
    while (dec_valid && guard < 10) begin
      tick();
      guard++;
    end
    tick();
    chk_eq("drain_valid", 64'(dec_valid), 64'(0));
    chk_eq("drain_queue", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Registered, parametrised successor to the 8-bit instruction ROM/decoder.
- Program memory and jump-label table are writable at run time; nothing is hard-coded.
- Fetch requests arrive with a valid/ready handshake. Decoded fields leave through a valid/ready handshake to the register file and ALU stage.
- Adds flush, out-of-range PC detection, and fully defined outputs: no X on any output.

Parameters:
- ADDR_W, 8, program memory address width; depth = 2**ADDR_W bytes.
- PC_W, 16, width of the PC, jump label entries and jmp_loc.
- LABEL_N, 16, jump-label table entries. Must be 16, because C-form indexes with instr[3:0].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program memory write enable.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  8  program write byte.
- lbl_we  in  1  label table write enable.
- lbl_idx  in  4  label index.
- lbl_data  in  PC_W  label value.
- fetch_valid  in  1  fetch request valid.
- fetch_ready  out  1  unit can accept a request.
- fetch_pc  in  PC_W  address to fetch.
- flush  in  1  discard all buffered decodes.
- dec_valid  out  1  decoded instruction valid.
- dec_ready  in  1  consumer accepts.
- dec_pc  out  PC_W  PC of the decoded instruction.
- format  out  2  C=00, I=01, M=10, X=11.
- opcode  out  4  instr[7:4].
- reg1_i  out  3  first source register.
- reg2_i  out  3  second source register.
- reg_o  out  3  destination register.
- imm  out  3  instr[3:1].
- imm_flag  out  1  instr[0].
- jmp_loc  out  PC_W  resolved jump target.
- oob  out  1  fetch_pc was beyond program depth.

Behaviour:
- Reset (async):
  - dec_valid=0, and all decode outputs, dec_pc and oob = 0.
  - Every label table entry = 0.
  - Program memory is not reset.
- Handshake:
  - Fetch is accepted when fetch_valid && fetch_ready.
  - Decode is consumed when dec_valid && dec_ready.
  - Outputs stay stable while dec_valid && !dec_ready.
- Latency: an accepted fetch appears on dec_* at the next rising edge, with dec_valid=1.
- Default buffering (one entry): fetch_ready = !dec_valid || dec_ready. Full throughput of one instruction per cycle.
- Format by opcode:
  - C-form: 0010, 0100.
  - I-form: 1001, 1101.
  - X-form: 1110, 1111.
  - M-form: all other opcodes.
- Registers:
  - C-form: reg_o = instr[0] ? 011 : 010; reg1_i = reg2_i = 0.
  - I-form: reg1_i = instr[3:1]; reg2_i = reg1_i+1 (mod 8, so 111 wraps to 000); reg_o = reg1_i.
  - M-form, opcode 0101 (MVB): reg1_i = {1,instr[1:0]}; reg_o = {0,instr[3:2]}; reg2_i = 0.
  - M-form, other opcodes: reg1_i = {0,instr[3:2]}; reg2_i = reg1_i+1; reg_o = {1,instr[1:0]}.
  - X-form: all register fields = 0.
- jmp_loc:
  - C-form: label[instr[3:0]].
  - M-form: label[{2'b11,instr[1:0]}], i.e. entries 12..15.
  - I-form and X-form: 0.
  - Label value is sampled at fetch acceptance. A later label write does not alter a buffered decode.
- Out-of-range PC: fetch_pc >= 2**ADDR_W (upper bits nonzero) decodes as 0xE0 (HALT, X-form) with oob=1. Otherwise oob=0.
- Simultaneous write and fetch:
  - prog_we to the same address as an accepted fetch: the fetch returns the new byte (write-first).
  - Label write to the index being resolved behaves the same way (write-first).
- Flush:
  - Next edge: dec_valid=0 and all buffered entries are dropped.
  - A fetch accepted in the same cycle as flush is also dropped.
  - fetch_ready during flush follows the normal rule.
- Reset mid-operation: buffered decodes are lost. Program memory is retained.

Optional Feature:
- Macro: INSTR_FETCH_SKID_EN.
- Defined:
  - Output buffer is a 2-entry FIFO.
  - fetch_ready = (count < 2), a function of registered state only, with no combinational path from dec_ready.
  - Order is preserved and throughput is one per cycle under a steady dec_ready.
  - Flush empties both entries.
  - An instruction accepted into an empty FIFO still appears on the next edge.
- Not defined: single-entry behaviour as above.

Test Plan:
- Load mem[0]=0x42 and label[2]=0x000A; fetch pc 0 → next cycle: dec_valid=1, format=00, opcode=0100, reg_o=010, jmp_loc=0x000A, oob=0.
- Load 0x76, 0x5A and 0xD1 at pc 1..3, with label[14]=0x0030 and dec_ready=1; fetch back-to-back →
  - 0x76: M-form, reg1_i=001, reg2_i=010, reg_o=110, jmp_loc=0x0030.
  - 0x5A: reg1_i=110, reg_o=010, reg2_i=000.
  - 0xD1: I-form, reg1_i=000, reg2_i=001, imm=000, imm_flag=1, jmp_loc=0.
  - One result per cycle.
- Hold dec_ready=0 for 3 cycles with fetch_valid=1 →
  - Default: fetch_ready=0 after the first accept.
  - Skid build: fetch_ready=0 after the second accept.
  - Outputs stable throughout; no request lost or duplicated once released.
- fetch_pc=0x0100 with ADDR_W=8 → opcode=1110, format=11, oob=1, all registers 0.
- prog_we to addr 5 with data 0xE0 in the same cycle as a fetch of pc 5 (old byte 0x01) → decode shows opcode 1110.
- Assert flush with one entry buffered and a concurrent fetch → next cycle dec_valid=0. Separately, assert reset mid-stream → dec_valid=0 immediately (async); mem[0] is still readable afterwards.
